fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address loaded into PCF on reset.
REQ-002 Parameter MEM_DEPTH, default 1024, number of words in the instruction memory fed by PCF.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 StallF  input  1  hold PCF (no sequential advance).
REQ-006 StallD  input  1  hold IF/ID register contents.
REQ-007 FlushD  input  1  clear IF/ID register (insert bubble).
REQ-008 PCSrcD  input  1  redirect request, branch/jump taken.
REQ-009 PCBranchD  input  32  redirect target, word address.
REQ-010 InstrF  input  32  instruction read combinationally from instruction memory at PCF.
REQ-011 PCF  output  32  current fetch word address, drives instruction memory index.
REQ-012 InstrD  output  32  instruction registered into decode.
REQ-013 PCPlus1D  output  32  registered PCF+1 of the instruction in decode.
REQ-014 ValidD  output  1  InstrD holds a real fetched instruction.

Function
REQ-015 PCF SHALL be a word address; the sequential next address SHALL be PCF+1, modulo 2^32.
REQ-016 FSM states RUN and DONE; reset state RUN.
REQ-017 PC update priority per edge: PCSrcD (PCF<=PCBranchD) > StallF (hold) > DONE (hold) > sequential (PCF<=PCF+1).
REQ-018 PCSrcD SHALL take effect even when StallF=1 or state=DONE; redirect in any state SHALL set state RUN.
REQ-019 In RUN, a sequential advance with PCF==MEM_DEPTH-1 SHALL leave PCF unchanged and set state DONE.
REQ-020 In DONE, PCF SHALL hold; sampled InstrF SHALL be treated as invalid.
REQ-021 PCBranchD>=MEM_DEPTH SHALL load unchanged into PCF and set DONE on the same edge.
REQ-022 IF/ID update priority per edge: FlushD (InstrD<=0, PCPlus1D<=0, ValidD<=0) > StallD (hold all) > capture.
REQ-023 Capture: InstrD<=InstrF, PCPlus1D<=PCF+1, ValidD<=1 when state RUN and StallF=0; else ValidD<=0, InstrD<=0.
REQ-024 Fetch-to-decode latency SHALL be exactly one cycle; one instruction per cycle with no stalls.
REQ-025 The last word (MEM_DEPTH-1) SHALL be captured with ValidD=1 exactly once before DONE yields bubbles.
REQ-026 StallF=1, StallD=0 SHALL produce a bubble (ValidD=0) the next cycle; the held instruction SHALL be re-captured when StallF drops.
REQ-027 PCSrcD does not flush; the hazard unit SHALL assert FlushD alongside PCSrcD to discard the wrong-path instruction.
REQ-028 No combinational path from any input to PCF; PCF, InstrD, PCPlus1D and ValidD SHALL be registered outputs.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock: PCF=RESET_PC, InstrD=0, PCPlus1D=0, ValidD=0, state RUN.
REQ-030 Reset asserted mid-stall, mid-redirect or in DONE SHALL override all inputs; first edge after release SHALL capture InstrF at RESET_PC.
REQ-031 rst_n deassertion SHALL be synchronized externally; the block imposes no other reset sequencing.

Verification
REQ-032 Reset release, memory word n = 32'h1000_0000+n, no stalls -> PCF 0,1,2,3 on consecutive edges; InstrD 32'h1000_0000 with PCPlus1D=1, ValidD=1 one cycle after PCF=0.
REQ-033 StallF=StallD=1 for 3 cycles at PCF=5 -> PCF stays 5, InstrD holds word 4; after release PCF=6 and InstrD=word 5 next cycle.
REQ-034 PCSrcD=1, FlushD=1, PCBranchD=40 at PCF=7 -> next edge PCF=40, ValidD=0; following edge InstrD=word 40, PCPlus1D=41.
REQ-035 MEM_DEPTH=8, free run -> PCF stops at 7, InstrD=word 7 with ValidD=1 once, then ValidD=0 indefinitely; PCSrcD with PCBranchD=2 -> PCF=2, RUN, fetch resumes.
REQ-036 Simultaneous FlushD=1 and StallD=1 -> ValidD=0, InstrD=0; simultaneous PCSrcD=1 and StallF=1 -> PCF=PCBranchD.
REQ-037 rst_n pulsed low between edges while PCF=12 in DONE -> outputs reset immediately, PCF=RESET_PC, fetch restarts from word 0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus between the fetch unit, the hazard unit, instruction memory and decode.
// Signals: StallF, StallD, FlushD, PCSrcD, PCBranchD and InstrF go into the fetch unit.
// PCF, InstrD, PCPlus1D and ValidD come out of it. slave = fetch unit side, master = environment.
interface fetch_if;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCPlus1D;
   logic        ValidD;

   modport slave (
      input  StallF, StallD, FlushD, PCSrcD, PCBranchD, InstrF,
      output PCF, InstrD, PCPlus1D, ValidD
   );

   modport master (
      output StallF, StallD, FlushD, PCSrcD, PCBranchD, InstrF,
      input  PCF, InstrD, PCPlus1D, ValidD
   );
endinterface

// File: rtl/fetch_unit.sv
// Word-addressed instruction fetch with PC register, RUN/DONE end-of-memory FSM and IF/ID register.
// Ports: clk, rst_n (async active-low), bus (fetch_if.slave: hazard controls, redirect, InstrF in;
// PCF, InstrD, PCPlus1D, ValidD out). Latency: one cycle fetch to decode; all outputs are registered.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_DEPTH = 1024
) (
   input  logic    clk,
   input  logic    rst_n,
   fetch_if.slave  bus
);

   localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);
   localparam logic [31:0] DEPTH   = 32'(MEM_DEPTH);

   typedef enum logic {RUN, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_q, pc_nx;
   logic [31:0] instr_q, instr_nx;
   logic [31:0] pcp1_q, pcp1_nx;
   logic        valid_q, valid_nx;
   logic [31:0] pc_plus1;

   assign pc_plus1 = pc_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         pcp1_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nx;
         pc_q    <= pc_nx;
         instr_q <= instr_nx;
         pcp1_q  <= pcp1_nx;
         valid_q <= valid_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      instr_nx = instr_q;
      pcp1_nx  = pcp1_q;
      valid_nx = valid_q;

      // PC: a redirect wins over everything, including a stall or DONE.
      // A target past the end of memory is loaded as-is but parks the FSM in DONE.
      if (bus.PCSrcD) begin
         pc_nx    = bus.PCBranchD;
         state_nx = (bus.PCBranchD >= DEPTH) ? DONE : RUN;
      end else if (bus.StallF || state == DONE) begin
         pc_nx = pc_q;
      end else if (pc_q == LAST_PC) begin
         // Last word is still captured below this edge; the PC stops here.
         state_nx = DONE;
      end else begin
         pc_nx = pc_plus1;
      end

      // IF/ID register. A stalled fetch or DONE state inserts a bubble.
      if (bus.FlushD) begin
         instr_nx = 32'd0;
         pcp1_nx  = 32'd0;
         valid_nx = 1'b0;
      end else if (bus.StallD) begin
         instr_nx = instr_q;
      end else if (state == RUN && !bus.StallF) begin
         instr_nx = bus.InstrF;
         pcp1_nx  = pc_plus1;
         valid_nx = 1'b1;
      end else begin
         instr_nx = 32'd0;
         pcp1_nx  = 32'd0;
         valid_nx = 1'b0;
      end
   end

   assign bus.PCF      = pc_q;
   assign bus.InstrD   = instr_q;
   assign bus.PCPlus1D = pcp1_q;
   assign bus.ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (MEM_DEPTH 64 and 8) share one stimulus stream.
// A behavioural model predicts every output each cycle; directed literal checks pin the model.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall_f, stall_d, flush_d, pcsrc_d;
   logic [31:0] tgt;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_if a();
   fetch_if b();

   assign a.StallF = stall_f;  assign b.StallF = stall_f;
   assign a.StallD = stall_d;  assign b.StallD = stall_d;
   assign a.FlushD = flush_d;  assign b.FlushD = flush_d;
   assign a.PCSrcD = pcsrc_d;  assign b.PCSrcD = pcsrc_d;
   assign a.PCBranchD = tgt;   assign b.PCBranchD = tgt;
   // Instruction memory contents: word n holds 32'h1000_0000 + n.
   assign a.InstrF = 32'h1000_0000 + a.PCF;
   assign b.InstrF = 32'h1000_0000 + b.PCF;

   fetch_unit #(.RESET_PC(32'd0), .MEM_DEPTH(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
   fetch_unit #(.RESET_PC(32'd0), .MEM_DEPTH(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] p);
      return 32'h1000_0000 + p;
   endfunction

   typedef struct {
      logic [31:0] pc;
      bit          done;
      logic [31:0] instr;
      logic [31:0] pcp1;
      bit          valid;
   } mstate_t;

   localparam mstate_t M_RST = '{pc: 32'd0, done: 1'b0, instr: 32'd0, pcp1: 32'd0, valid: 1'b0};

   // One clock edge of the fetch rules, given the inputs present at that edge.
   function automatic mstate_t nxt(input mstate_t s, input int depth,
                                   input logic sf, input logic sd, input logic fd,
                                   input logic ps, input logic [31:0] t);
      mstate_t r = s;
      bit fetching = !s.done && !sf;
      if (fd) begin
         r.instr = 0; r.pcp1 = 0; r.valid = 0;
      end else if (!sd) begin
         r.valid = fetching;
         r.instr = fetching ? word(s.pc) : 32'd0;
         r.pcp1  = fetching ? s.pc + 32'd1 : 32'd0;
      end
      if (ps) begin
         r.pc = t;
         r.done = (t >= 32'(depth));
      end else if (fetching) begin
         if (s.pc == 32'(depth - 1)) r.done = 1'b1;
         else r.pc = s.pc + 32'd1;
      end
      return r;
   endfunction

   mstate_t ma, mb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= M_RST;
         mb <= M_RST;
      end else begin
         ma <= nxt(ma, 64, stall_f, stall_d, flush_d, pcsrc_d, tgt);
         mb <= nxt(mb, 8,  stall_f, stall_d, flush_d, pcsrc_d, tgt);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("A_PCF",    a.PCF,              ma.pc);
         chk("A_ValidD", {31'd0, a.ValidD},  {31'd0, ma.valid});
         chk("A_InstrD", a.InstrD,           ma.instr);
         if (ma.valid) chk("A_PCPlus1D", a.PCPlus1D, ma.pcp1);
         chk("B_PCF",    b.PCF,              mb.pc);
         chk("B_ValidD", {31'd0, b.ValidD},  {31'd0, mb.valid});
         chk("B_InstrD", b.InstrD,           mb.instr);
         if (mb.valid) chk("B_PCPlus1D", b.PCPlus1D, mb.pcp1);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_d = 0; tgt = 0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      idle();
      #1;
      chk("rst_A_PCF",    a.PCF, 32'd0);
      chk("rst_A_ValidD", {31'd0, a.ValidD}, 32'd0);
      chk("rst_A_InstrD", a.InstrD, 32'd0);
      chk("rst_A_PCPlus1D", a.PCPlus1D, 32'd0);
      step(); step();
      rst_n = 1'b1;

      // Free run from reset.
      step();
      chk("run_PCF1",    a.PCF, 32'd1);
      chk("run_InstrD0", a.InstrD, 32'h1000_0000);
      chk("run_PCP1",    a.PCPlus1D, 32'd1);
      chk("run_ValidD",  {31'd0, a.ValidD}, 32'd1);
      step(); chk("run_PCF2", a.PCF, 32'd2);
      step(); chk("run_PCF3", a.PCF, 32'd3);
      step(); step();
      chk("run_PCF5", a.PCF, 32'd5);

      // Full stall for three edges at PCF=5.
      stall_f = 1; stall_d = 1;
      repeat (3) step();
      chk("stall_PCF",    a.PCF, 32'd5);
      chk("stall_InstrD", a.InstrD, 32'h1000_0004);
      stall_f = 0; stall_d = 0;
      step();
      chk("unstall_PCF",    a.PCF, 32'd6);
      chk("unstall_InstrD", a.InstrD, 32'h1000_0005);
      step();
      chk("pre_br_PCF", a.PCF, 32'd7);

      // Redirect with flush to 40; B (depth 8) goes out of range.
      pcsrc_d = 1; flush_d = 1; tgt = 32'd40;
      step();
      chk("br_PCF",    a.PCF, 32'd40);
      chk("br_ValidD", {31'd0, a.ValidD}, 32'd0);
      chk("br_B_PCF",  b.PCF, 32'd40);
      idle();
      step();
      chk("br_InstrD", a.InstrD, 32'h1000_0028);
      chk("br_PCP1",   a.PCPlus1D, 32'd41);
      chk("br_B_ValidD", {31'd0, b.ValidD}, 32'd0);

      // Flush beats stall.
      flush_d = 1; stall_d = 1;
      step();
      chk("fl_st_ValidD", {31'd0, a.ValidD}, 32'd0);
      chk("fl_st_InstrD", a.InstrD, 32'd0);

      // Redirect beats StallF; brings B back to RUN.
      idle();
      pcsrc_d = 1; stall_f = 1; flush_d = 1; tgt = 32'd2;
      step();
      chk("br_stf_A_PCF", a.PCF, 32'd2);
      chk("br_stf_B_PCF", b.PCF, 32'd2);
      idle();

      // B runs into the end of its memory: word 7 exactly once.
      cnt = 0;
      repeat (12) begin
         step();
         if (b.ValidD && b.InstrD == 32'h1000_0007) cnt++;
      end
      chk("B_last_once",  32'(cnt), 32'd1);
      chk("B_done_PCF",   b.PCF, 32'd7);
      chk("B_done_Valid", {31'd0, b.ValidD}, 32'd0);
      pcsrc_d = 1; tgt = 32'd2;
      step();
      chk("B_resume_PCF", b.PCF, 32'd2);
      idle();
      step();
      chk("B_resume_Valid", {31'd0, b.ValidD}, 32'd1);
      chk("B_resume_Instr", b.InstrD, 32'h1000_0002);
      chk("B_resume_PCF3",  b.PCF, 32'd3);

      // Async reset between edges while B sits at 12 in DONE.
      pcsrc_d = 1; tgt = 32'd12;
      step();
      idle();
      step(); step();
      chk("B_12_PCF",   b.PCF, 32'd12);
      chk("B_12_Valid", {31'd0, b.ValidD}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_B_PCF",   b.PCF, 32'd0);
      chk("arst_B_Valid", {31'd0, b.ValidD}, 32'd0);
      chk("arst_B_Instr", b.InstrD, 32'd0);
      chk("arst_B_PCP1",  b.PCPlus1D, 32'd0);
      chk("arst_A_PCF",   a.PCF, 32'd0);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_B_PCF",   b.PCF, 32'd1);
      chk("post_rst_B_Instr", b.InstrD, 32'h1000_0000);
      chk("post_rst_B_Valid", {31'd0, b.ValidD}, 32'd1);

      // Randomized phase, checked every cycle by the model compare.
      repeat (3000) begin
         stall_f = ($urandom_range(0, 3) == 0);
         stall_d = ($urandom_range(0, 4) == 0);
         flush_d = ($urandom_range(0, 5) == 0);
         pcsrc_d = ($urandom_range(0, 7) == 0);
         tgt     = 32'($urandom_range(0, 70));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk("rnd_arst_A_PCF", a.PCF, 32'd0);
            #1 rst_n = 1'b1;
         end
         step();
      end

      idle();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
